// File: rtl/axi_slv_mem.sv
// AXI4 slave memory responder: INCR bursts up to 16 beats over a DEPTH x DATA_WIDTH dual-port RAM.
// Independent read and write channels, one outstanding transaction per direction.
module axi_slv_mem #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [31:0]             s_axi_awaddr,
    input  logic [3:0]              s_axi_awlen,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [31:0]             s_axi_araddr,
    input  logic [3:0]              s_axi_arlen,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned HI     = LSB + IDX_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    // write channel state
    w_state_t            w_state, w_state_d;
    logic [ID_WIDTH-1:0] w_id, w_id_d;
    logic [IDX_W-1:0]    w_idx, w_idx_d;
    logic [3:0]          w_len, w_len_d;
    logic [3:0]          w_cnt, w_cnt_d;
    logic                w_oor, w_oor_d;
    logic                w_err, w_err_d;
    logic                awready_d, wready_d, bvalid_d;
    logic [ID_WIDTH-1:0] bid_d;
    logic [1:0]          bresp_d;
    logic                wr_en_c;

    // read channel state
    r_state_t            r_state, r_state_d;
    logic [ID_WIDTH-1:0] r_id, r_id_d;
    logic [3:0]          r_len, r_len_d;
    logic [IDX_W-1:0]    r_idx, r_idx_d;
    logic [4:0]          r_icnt, r_icnt_d;
    logic                r_oor, r_oor_d;
    logic                q_valid, q_valid_d;
    logic                q_last, q_last_d;
    logic                arready_d, rvalid_d, rlast_d;
    logic [ID_WIDTH-1:0] rid_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]          rresp_d;
    logic                rd_en_c;
    logic [IDX_W-1:0]    rd_idx_c;
    logic                out_free_c, q_move_c;

    // RAM: byte-enabled write port, registered read port (read-before-write)
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
        if (rd_en_c) begin
            ram_q <= mem[rd_idx_c];
        end
    end

    // write FSM next-state
    always_comb begin
        w_state_d = w_state;
        w_id_d    = w_id;
        w_idx_d   = w_idx;
        w_len_d   = w_len;
        w_cnt_d   = w_cnt;
        w_oor_d   = w_oor;
        w_err_d   = w_err;
        bid_d     = s_axi_bid;
        bresp_d   = s_axi_bresp;
        wr_en_c   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_awready) begin
                    w_id_d    = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[LSB +: IDX_W];
                    w_len_d   = s_axi_awlen;
                    w_cnt_d   = 4'd0;
                    w_oor_d   = (s_axi_awaddr >> HI) != 32'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && s_axi_wready) begin
                    wr_en_c = !w_oor;
                    w_idx_d = w_idx + IDX_W'(1);
                    w_cnt_d = w_cnt + 4'd1;
                    if (s_axi_wlast != (w_cnt == w_len)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_cnt == w_len) begin
                        bid_d     = w_id;
                        bresp_d   = (w_oor || w_err_d) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bvalid && s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            w_id          <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_oor         <= 1'b0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= '0;
        end else begin
            w_state       <= w_state_d;
            w_id          <= w_id_d;
            w_idx         <= w_idx_d;
            w_len         <= w_len_d;
            w_cnt         <= w_cnt_d;
            w_oor         <= w_oor_d;
            w_err         <= w_err_d;
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bid     <= bid_d;
            s_axi_bresp   <= bresp_d;
        end
    end

    // read FSM: ram_q acts as the prefetch slot feeding the R output register
    always_comb begin
        r_state_d = r_state;
        r_id_d    = r_id;
        r_len_d   = r_len;
        r_idx_d   = r_idx;
        r_icnt_d  = r_icnt;
        r_oor_d   = r_oor;
        q_valid_d = q_valid;
        q_last_d  = q_last;
        rvalid_d  = s_axi_rvalid;
        rlast_d   = s_axi_rlast;
        rid_d     = s_axi_rid;
        rdata_d   = s_axi_rdata;
        rresp_d   = s_axi_rresp;
        rd_en_c   = 1'b0;
        rd_idx_c  = r_idx;
        out_free_c = !s_axi_rvalid || s_axi_rready;
        q_move_c   = q_valid && out_free_c;
        case (r_state)
            R_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    r_id_d    = s_axi_arid;
                    r_len_d   = s_axi_arlen;
                    r_oor_d   = (s_axi_araddr >> HI) != 32'd0;
                    rd_en_c   = 1'b1;
                    rd_idx_c  = s_axi_araddr[LSB +: IDX_W];
                    r_idx_d   = s_axi_araddr[LSB +: IDX_W] + IDX_W'(1);
                    r_icnt_d  = 5'd1;
                    q_valid_d = 1'b1;
                    q_last_d  = (s_axi_arlen == 4'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (q_move_c) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = r_oor ? '0 : ram_q;
                    rresp_d   = r_oor ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = q_last;
                    rid_d     = r_id;
                    q_valid_d = 1'b0;
                end else if (s_axi_rvalid && s_axi_rready) begin
                    rvalid_d = 1'b0;
                end
                if ((r_icnt <= {1'b0, r_len}) && (!q_valid || q_move_c)) begin
                    rd_en_c   = 1'b1;
                    r_idx_d   = r_idx + IDX_W'(1);
                    r_icnt_d  = r_icnt + 5'd1;
                    q_valid_d = 1'b1;
                    q_last_d  = (r_icnt == {1'b0, r_len});
                end
                if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            r_id          <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_icnt        <= '0;
            r_oor         <= 1'b0;
            q_valid       <= 1'b0;
            q_last        <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
        end else begin
            r_state       <= r_state_d;
            r_id          <= r_id_d;
            r_len         <= r_len_d;
            r_idx         <= r_idx_d;
            r_icnt        <= r_icnt_d;
            r_oor         <= r_oor_d;
            q_valid       <= q_valid_d;
            q_last        <= q_last_d;
            s_axi_arready <= arready_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rlast   <= rlast_d;
            s_axi_rid     <= rid_d;
            s_axi_rdata   <= rdata_d;
            s_axi_rresp   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Scoreboard bench for axi_slv_mem: a word-array memory model predicts B and R responses.
module tb_axi_slv_mem;
    localparam int unsigned ID_W = 1;
    localparam int unsigned DW   = 64;
    localparam int MDEPTH        = 1024;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
        logic            last;
        logic [DW-1:0]   data;
    } rbeat_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } bexp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [ID_W-1:0] s_axi_awid;
    logic [31:0]     s_axi_awaddr;
    logic [3:0]      s_axi_awlen;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic            s_axi_wlast;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [ID_W-1:0] s_axi_bid;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [ID_W-1:0] s_axi_arid;
    logic [31:0]     s_axi_araddr;
    logic [3:0]      s_axi_arlen;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [ID_W-1:0] s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rvalid;
    logic            s_axi_rready;

    rbeat_t        exp_r [$];
    bexp_t         exp_b [$];
    logic [DW-1:0] model [MDEPTH];
    logic [DW-1:0] wdat  [16];
    int vecs = 0;
    int errs = 0;

    axi_slv_mem #(.ID_WIDTH(ID_W), .DATA_WIDTH(DW), .DEPTH(MDEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog");
    end

    // Write burst: update model, push expected B, drive AW/W, check B.
    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [7:0] strb, input int early);
        logic  oor;
        int    idx;
        int    n;
        bexp_t e;
        oor = (addr >> 13) != 32'd0;
        idx = int'(addr[12:3]);
        for (int i = 0; i <= len; i++) begin
            if (!oor) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) model[(idx + i) % MDEPTH][8*b +: 8] = wdat[i][8*b +: 8];
                end
            end
        end
        e.id   = id;
        e.resp = (oor || early >= 0) ? 2'b10 : 2'b00;
        exp_b.push_back(e);

        @(negedge clk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 4'(len); s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vecs++;
        if (n >= 100) begin errs++; $display("FAIL aw_timeout: awready got %b required 1", s_axi_awready); end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        vecs++;
        if (s_axi_awready !== 1'b0) begin errs++; $display("FAIL aw_drop: awready got %b required 0", s_axi_awready); end

        for (int i = 0; i <= len; i++) begin
            s_axi_wdata  = wdat[i];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (early >= 0) ? (i == early) : (i == len);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (s_axi_wready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) begin
                vecs++; errs++;
                $display("FAIL w_timeout: beat %0d wready got %b required 1", i, s_axi_wready);
            end
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;

        s_axi_bready = 1'b1;
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vecs++;
        if (n >= 100) begin errs++; $display("FAIL b_timeout: bvalid got %b required 1", s_axi_bvalid); end
        e = exp_b.pop_front();
        vecs++;
        if (s_axi_bid !== e.id || s_axi_bresp !== e.resp) begin
            errs++;
            $display("FAIL b_resp: got bid=%0h bresp=%b required bid=%0h bresp=%b",
                     s_axi_bid, s_axi_bresp, e.id, e.resp);
        end
        @(negedge clk);
        s_axi_bready = 1'b0;
        vecs++;
        if (s_axi_bvalid !== 1'b0) begin errs++; $display("FAIL b_drop: bvalid got %b required 0", s_axi_bvalid); end
    endtask

    // Read burst: push expected beats, drive AR, collect R with optional rready toggling.
    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input bit toggle, input int abort_at, input bit check_timing);
        logic   oor;
        int     idx, n, k, done, first_n, last_n;
        bit     hold_v;
        rbeat_t hold, got, e;
        oor = (addr >> 13) != 32'd0;
        idx = int'(addr[12:3]);
        for (int i = 0; i <= len; i++) begin
            e.id   = id;
            e.resp = oor ? 2'b10 : 2'b00;
            e.last = (i == len);
            e.data = oor ? '0 : model[(idx + i) % MDEPTH];
            exp_r.push_back(e);
        end

        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 4'(len); s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vecs++;
        if (n >= 100) begin errs++; $display("FAIL ar_timeout: arready got %b required 1", s_axi_arready); end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        vecs++;
        if (s_axi_arready !== 1'b0) begin errs++; $display("FAIL ar_drop: arready got %b required 0", s_axi_arready); end

        n = 1; k = 0; done = 0; first_n = -1; last_n = -1; hold_v = 0;
        while (exp_r.size() > 0 && n < 300 && !(abort_at >= 0 && done == abort_at)) begin
            s_axi_rready = toggle ? ((k % 3) == 0) : 1'b1;
            k++;
            got.id = s_axi_rid; got.resp = s_axi_rresp; got.last = s_axi_rlast; got.data = s_axi_rdata;
            if (hold_v) begin
                vecs++;
                if (s_axi_rvalid !== 1'b1 || got !== hold) begin
                    errs++;
                    $display("FAIL r_stall_hold: got v=%b data=%h last=%b required v=1 data=%h last=%b",
                             s_axi_rvalid, got.data, got.last, hold.data, hold.last);
                end
            end
            hold_v = 0;
            if (s_axi_rvalid === 1'b1) begin
                if (first_n < 0) first_n = n;
                if (s_axi_rready) begin
                    e = exp_r.pop_front();
                    vecs++;
                    if (got !== e) begin
                        errs++;
                        $display("FAIL r_beat %0d: got id=%0h resp=%b last=%b data=%h required id=%0h resp=%b last=%b data=%h",
                                 done, got.id, got.resp, got.last, got.data, e.id, e.resp, e.last, e.data);
                    end
                    done++;
                    last_n = n;
                end else begin
                    hold_v = 1;
                    hold   = got;
                end
            end
            @(negedge clk);
            n++;
        end
        if (abort_at < 0) begin
            s_axi_rready = 1'b0;
            vecs++;
            if (exp_r.size() != 0) begin
                errs++;
                $display("FAIL r_timeout: got %0d beats outstanding required 0", exp_r.size());
                exp_r.delete();
            end
            vecs++;
            if (s_axi_rvalid !== 1'b0) begin errs++; $display("FAIL r_extra: rvalid got %b required 0", s_axi_rvalid); end
            if (check_timing) begin
                vecs++;
                if (first_n != 2) begin errs++; $display("FAIL r_latency: first rvalid got cycle %0d required 2", first_n); end
                vecs++;
                if (last_n - first_n != len) begin
                    errs++;
                    $display("FAIL r_gap: burst span got %0d cycles required %0d", last_n - first_n, len);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rresp, s_axi_rdata} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got awr=%b arr=%b bv=%b rv=%b rdata=%h required all 0",
                     s_axi_awready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release: got awready=%b arready=%b required 1 1", s_axi_awready, s_axi_arready);
        end
    endtask

    task automatic test_single();
        wdat[0] = 64'h1122334455667788;
        do_write(1'b1, 32'h10, 0, 8'hFF, -1);
        do_read(1'b1, 32'h10, 0, 1'b0, -1, 1'b1);
    endtask

    task automatic test_burst16();
        for (int i = 0; i < 16; i++) wdat[i] = 64'(i);
        do_write(1'b0, 32'h100, 15, 8'hFF, -1);
        do_read(1'b0, 32'h100, 15, 1'b0, -1, 1'b1);
    endtask

    task automatic test_strobe();
        wdat[0] = '1;
        do_write(1'b0, 32'h200, 0, 8'hFF, -1);
        wdat[0] = '0;
        do_write(1'b0, 32'h200, 0, 8'h0F, -1);
        do_read(1'b1, 32'h200, 0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 4; i++) wdat[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        do_write(1'b0, 32'h0, 3, 8'hFF, -1);
        for (int i = 0; i < 4; i++) wdat[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        do_write(1'b1, 32'h2000, 3, 8'hFF, -1);
        do_read(1'b0, 32'h0, 3, 1'b0, -1, 1'b0);
        do_read(1'b1, 32'h2000, 3, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) wdat[i] = {32'($urandom), 32'($urandom)};
        do_write(1'b1, 32'h400, 7, 8'hFF, -1);
        do_read(1'b1, 32'h400, 7, 1'b1, -1, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wdat[i] = 64'hC0DE_0000_0000_0000 | 64'(i + 1);
        do_write(1'b0, 32'h1FF0, 3, 8'hFF, -1);
        do_read(1'b0, 32'h1FF0, 3, 1'b0, -1, 1'b0);
        do_read(1'b1, 32'h0, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_wlast_early();
        for (int i = 0; i < 4; i++) wdat[i] = 64'h7777_0000_0000_0000 | 64'(i);
        do_write(1'b1, 32'h600, 3, 8'hFF, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) wdat[i] = 64'h5555_0000_0000_0000 | 64'(i);
        fork
            do_write(1'b1, 32'h800, 7, 8'hFF, -1);
            do_read(1'b0, 32'h100, 15, 1'b0, -1, 1'b1);
        join
        do_read(1'b1, 32'h800, 7, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        do_read(1'b0, 32'h100, 7, 1'b0, 2, 1'b0);
        vecs++;
        if (s_axi_rvalid !== 1'b1) begin errs++; $display("FAIL mid_read_active: rvalid got %b required 1", s_axi_rvalid); end
        rst = 1'b1;
        #1;
        vecs++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
            errs++;
            $display("FAIL mid_read_reset: got rvalid=%b arready=%b required 0 0", s_axi_rvalid, s_axi_arready);
        end
        exp_r.delete();
        s_axi_rready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL mid_read_release: got arready=%b rvalid=%b required 1 0", s_axi_arready, s_axi_rvalid);
        end
        do_read(1'b1, 32'h10, 0, 1'b0, -1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;

        test_reset();
        test_single();
        test_burst16();
        test_strobe();
        test_out_of_range();
        test_backpressure();
        test_wrap();
        test_wlast_early();
        test_back_to_back();
        test_reset_mid_read();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/axi_slv_mem.md
Name: axi_slv_mem

Overview:
- AXI4 slave memory responder, the far end of the team's AXI master read/write engines.
- Serves INCR bursts of up to 16 beats from an internal dual-port RAM of DEPTH x DATA_WIDTH.
- Independent read and write channels; one outstanding transaction per direction.
- AxLOCK/CACHE/PROT/REGION/QOS/SIZE/BURST are not ported: full-width INCR is implied.

Parameters:
ID_WIDTH, 1, width of AXI ID fields
DATA_WIDTH, 64, data bus width in bits (power of 2, >=32)
DEPTH, 1024, memory words (power of 2); byte span = DEPTH*DATA_WIDTH/8

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  32  write byte address
s_axi_awlen  in  4  beats-1
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  OKAY=00 / SLVERR=10
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  32  read byte address
s_axi_arlen  in  4  beats-1
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  OKAY / SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset values: all outputs 0. awready and arready rise in the first cycle after rst deasserts. RAM contents are not reset.
- Word index = addr[LSB +: log2(DEPTH)], with LSB = log2(DATA_WIDTH/8). Low LSB address bits are ignored.
- A burst is out of range if any addr bit at or above LSB+log2(DEPTH) is set. Out-of-range bursts:
  - complete all beats;
  - suppress RAM writes;
  - return rdata=0;
  - respond SLVERR.
- In-range beat indices increment by 1 per beat and wrap modulo DEPTH.
- Write FSM:
  - W_IDLE (awready=1): on awvalid latch id, addr, len; clear beat counter; go to W_DATA. awready is 0 the next cycle.
  - W_DATA (wready=1): each wvalid&&wready writes the RAM with per-byte wstrb, then the counter increments.
  - On the beat where counter==len, go to W_RESP.
  - wlast must be 1 exactly on beat len. Any mismatch sets a sticky error; the burst still ends after len+1 beats.
  - W_RESP (bvalid=1, bid=latched id, bresp=SLVERR if out-of-range or error else OKAY): on bready go to W_IDLE.
  - Earliest next awready is the cycle after the B handshake.
- Read FSM:
  - R_IDLE (arready=1): on arvalid latch id, addr, len; go to R_DATA. arready is 0 the next cycle.
  - RAM has 1-cycle read latency. First rvalid is asserted 2 cycles after the AR handshake.
  - With rready held 1, throughput is 1 beat/cycle. A prefetch/skid register is required, with no bubbles.
  - While rvalid && !rready: rdata, rid, rresp and rlast hold stable.
  - rlast=1 on beat len. On the rlast handshake return to R_IDLE.
- Simultaneous events:
  - AW and AR accepted in the same cycle proceed independently.
  - Same-cycle read and write of the same word: read returns the old data.
- rst mid-burst: both FSMs return to idle and in-flight transactions are dropped. Beats already written stay in the RAM.

Test Plan:
- Single beat: write awaddr=0x10, len=0, wdata=0x1122334455667788, wstrb=0xFF → bresp=00, bid echoes. Then read 0x10 → rdata=0x1122334455667788, rlast=1, rresp=00.
- 16-beat burst at 0x100, data=beat index, rready=1 throughout → read back 0..15 on 16 consecutive cycles, rlast only on the 16th, first rvalid 2 cycles after AR.
- Byte strobes: write 0xFFFF..FF, then wstrb=0x0F with data 0 at the same address → read 0xFFFFFFFF00000000.
- awaddr=0x2000 (DEPTH=1024, 64-bit), len=3 → 4 W beats accepted, bresp=10, RAM unchanged. araddr=0x2000 → 4 beats of 0, rresp=10.
- Backpressure: 8-beat read with rready toggling 1,0,0,1,... → data stable during stalls, correct order, no lost or duplicated beats. Wrap: write at word 1022 with len=3 → words 1022, 1023, 0, 1.
- wlast early on beat 1 of a len=3 burst → bresp=10 after 4 beats. Assert rst during beat 2 of an 8-beat read → rvalid=0 immediately; arready=1 after reset release.
